// File: rtl/helios_stream_fifo.sv
// Single-clock valid/ready stream FIFO with a first-word-fall-through read port.
// Buffers the 32-bit host streams around the Helios decoder core.
module helios_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] output_data,
  output logic             output_valid,
  input  logic             output_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_wr_ptr_nxt;
  logic [AW-1:0]    w_rd_ptr_nxt;

  // Flags look only at state and reset, so input_ready never waits on output_ready.
  assign input_ready  = (r_count != FULL_CNT) && !reset;
  assign output_valid = (r_count != '0) && !reset;
  assign output_data  = r_mem[r_rd_ptr];

  assign w_push = input_valid && input_ready;
  assign w_pop  = output_valid && output_ready;

  // Explicit wrap so non-power-of-two depths work.
  assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= input_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_helios_stream_fifo.sv
// Directed/scoreboard bench for helios_stream_fifo: reference queue model,
// flag checks every cycle, plus hand-computed data expectations per scenario.
module tb_helios_stream_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 128;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] input_data;
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] output_data;
  logic             output_valid;
  logic             output_ready;

  int n_checks;
  int n_fail;

  logic [31:0] q[$];
  logic        popped;
  logic [31:0] pword;

  helios_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: drive after the falling edge, check flags/head against the model,
  // then advance the model on the rising edge.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy, input logic rst);
    logic exp_ir, exp_ov, push, pop;
    input_valid  = iv;
    input_data   = d;
    output_ready = ordy;
    reset        = rst;
    #1;
    exp_ir = !rst && (q.size() != DEPTH);
    exp_ov = !rst && (q.size() != 0);
    chk("in_ready", {31'd0, input_ready}, {31'd0, exp_ir});
    chk("out_valid", {31'd0, output_valid}, {31'd0, exp_ov});
    if (exp_ov) chk("out_data", output_data, q[0]);
    push = iv && exp_ir;
    pop  = exp_ov && ordy;
    popped = 1'b0;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (pop) begin
        pword  = q.pop_front();
        popped = 1'b1;
      end
      if (push) q.push_back(d);
    end
    @(negedge clk);
  endtask

  logic [31:0] rnd_words [1000];

  initial begin
    int n_in, n_out, budget;
    n_checks = 0;
    n_fail   = 0;
    popped   = 1'b0;
    pword    = '0;
    input_valid  = 1'b0;
    input_data   = '0;
    output_ready = 1'b0;
    reset        = 1'b1;

    // Reset, single word round trip
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    chk("idle_ready", {31'd0, input_ready}, 32'd1);
    chk("idle_valid", {31'd0, output_valid}, 32'd0);
    cyc(1, 32'h0000_0001, 1, 0);
    chk("first_valid", {31'd0, output_valid}, 32'd1);
    chk("first_data", output_data, 32'h0000_0001);
    cyc(0, 0, 1, 0);
    chk("first_pop", {31'd0, popped}, 32'd1);
    chk("after_pop_valid", {31'd0, output_valid}, 32'd0);

    // Fill to DEPTH with output stalled, then an extra rejected push
    for (int i = 0; i < DEPTH; i++) cyc(1, i, 0, 0);
    chk("full_ready", {31'd0, input_ready}, 32'd0);
    cyc(1, 32'hDEAD_BEEF, 0, 0);
    chk("full_hold_ready", {31'd0, input_ready}, 32'd0);
    chk("full_head", output_data, 32'd0);

    // Full + push attempt + pop: only the pop happens
    cyc(1, 32'h0000_0777, 1, 0);
    chk("fullpop_word", pword, 32'd0);
    chk("fullpop_ready", {31'd0, input_ready}, 32'd1);
    cyc(1, 32'd999, 0, 0);
    chk("refill_ready", {31'd0, input_ready}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", output_data, (i < DEPTH - 1) ? i + 1 : 999);
      cyc(0, 0, 1, 0);
    end
    chk("drained_valid", {31'd0, output_valid}, 32'd0);

    // Continuous streaming: output is input delayed by one cycle, pointers wrap
    for (int k = 0; k < 300; k++) begin
      if (k > 0) chk("stream_data", output_data, k - 1);
      cyc(1, k, 1, 0);
      if (k > 0) chk("stream_level", q.size(), 32'd1);
    end
    cyc(0, 0, 1, 0);
    chk("stream_last", pword, 32'd299);

    // Random handshakes over 1000 words
    for (int j = 0; j < 1000; j++) rnd_words[j] = j * 32'h9E37_79B9 + 32'h1234_5678;
    rnd_words[500] = 32'hFFFF_FFFF;
    n_in = 0;
    n_out = 0;
    budget = 0;
    while (n_out < 1000 && budget < 20000) begin
      logic iv, ordy, acc;
      iv   = (n_in < 1000) && ($urandom_range(1, 0) == 1);
      ordy = ($urandom_range(1, 0) == 1);
      acc  = iv && (q.size() != DEPTH);
      cyc(iv, (n_in < 1000) ? rnd_words[n_in] : 32'h0, ordy, 0);
      if (acc) n_in++;
      if (popped) begin
        chk("rnd_word", pword, rnd_words[n_out]);
        n_out++;
      end
      budget++;
    end
    chk("rnd_count", n_out, 32'd1000);

    // Reset mid-stream discards buffered words
    for (int i = 0; i < 5; i++) cyc(1, 32'h5000 + i, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("post_rst_ready", {31'd0, input_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, output_valid}, 32'd0);
    cyc(1, 32'hABCD_0123, 0, 0);
    chk("post_rst_data", output_data, 32'hABCD_0123);
    cyc(0, 0, 1, 0);
    chk("post_rst_pop", pword, 32'hABCD_0123);
    chk("post_rst_empty", {31'd0, output_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
